// File: rtl/core_bus_master_if.sv
// Core bus as seen by the bus master: one strobe/ack cycle carrying address,
// byte enables and write data out, read data back.
interface core_bus_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   io_addr;
    logic [DATA_W-1:0]   io_dat2;
    logic [DATA_W-1:0]   io_dat4;
    logic [DATA_W/8-1:0] io_be;
    logic                io_sel;
    logic                io_we;
    logic                io_ack;

    modport master (
        output io_addr, io_dat2, io_be, io_sel, io_we,
        input  io_dat4, io_ack
    );

    modport slave (
        input  io_addr, io_dat2, io_be, io_sel, io_we,
        output io_dat4, io_ack
    );
endinterface

// File: rtl/core_bus_master.sv
// Multi-channel front-end for the core bus: arbitrates N_CH requesters, runs one
// bus cycle at a time with an optional ack timeout, and returns a one-cycle response.
//
// state | meaning
// IDLE  | arbitrate; req_ready to the winner, capture its request on the edge
// BUS   | io_sel high, wait for io_ack or timeout
// RESP  | resp_valid pulse to the granted channel
module core_bus_master #(
    parameter int N_CH    = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int ARB_RR  = 1,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_CH-1:0]          req_valid,
    output logic [N_CH-1:0]          req_ready,
    input  logic [N_CH-1:0]          req_we,
    input  logic [N_CH*ADDR_W-1:0]   req_addr,
    input  logic [N_CH*DATA_W-1:0]   req_wdata,
    input  logic [N_CH*DATA_W/8-1:0] req_be,
    output logic [N_CH-1:0]          resp_valid,
    output logic [DATA_W-1:0]        resp_rdata,
    output logic                     resp_err,
    core_bus_master_if.master        bus
);
    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 2);
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t            state;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  g_q;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;
    logic              we_q;
    logic              sel_q;

    logic              gnt_found;
    logic [IDX_W-1:0]  gnt_idx;
    int                cand;
    logic [N_CH-1:0]   resp_onehot;

    // Round-robin scans from the channel after the last winner; fixed priority scans from ch0.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int i = 0; i < N_CH; i++) begin
            cand = (ARB_RR != 0) ? (int'(rr_ptr) + 1 + i) % N_CH : i;
            if (!gnt_found && req_valid[IDX_W'(cand)]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDX_W'(cand);
            end
        end
    end

    // Gated by reset so the handshake drops together with the registered outputs.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && reset && gnt_found)
            req_ready[gnt_idx] = 1'b1;
    end

    always_comb begin
        resp_onehot      = '0;
        resp_onehot[g_q] = 1'b1;
    end

    assign cnt_inc = cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            rr_ptr     <= IDX_W'(N_CH - 1);
            g_q        <= '0;
            cnt        <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            we_q       <= 1'b0;
            sel_q      <= 1'b0;
            resp_valid <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= '0;
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        g_q     <= gnt_idx;
                        rr_ptr  <= gnt_idx;
                        addr_q  <= req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
                        wdata_q <= req_we[gnt_idx] ? req_wdata[int'(gnt_idx)*DATA_W +: DATA_W] : '0;
                        be_q    <= req_be[int'(gnt_idx)*BE_W +: BE_W];
                        we_q    <= req_we[gnt_idx];
                        sel_q   <= 1'b1;
                        state   <= BUS;
                    end
                end
                BUS: begin
                    cnt <= cnt_inc;
                    if (bus.io_ack) begin
                        sel_q      <= 1'b0;
                        resp_rdata <= we_q ? '0 : bus.io_dat4;
                        resp_err   <= 1'b0;
                        resp_valid <= resp_onehot;
                        state      <= RESP;
                    end else if (TIMEOUT != 0 && cnt_inc == TO_VAL) begin
                        sel_q      <= 1'b0;
                        resp_rdata <= '0;
                        resp_err   <= 1'b1;
                        resp_valid <= resp_onehot;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.io_addr = addr_q;
    assign bus.io_dat2 = wdata_q;
    assign bus.io_be   = be_q;
    assign bus.io_we   = we_q;
    assign bus.io_sel  = sel_q;
endmodule

// File: tb/tb_core_bus_master.sv
// Randomized bench for core_bus_master against a transaction-level model of
// arbitration, bus timing, timeout and response data.
module tb_core_bus_master;
    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req_valid, req_we;
    logic [N-1:0]  req_ready, resp_valid;
    logic [N-1:0]  req_ready2, resp_valid2;
    logic [63:0]   req_addr, req_wdata;
    logic [7:0]    req_be;
    logic [31:0]   resp_rdata, resp_rdata2;
    logic          resp_err, resp_err2;

    int total = 0;
    int bad   = 0;
    int last_g;
    logic [31:0] last_rdata;
    logic        last_err;

    core_bus_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    core_bus_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus2 ();

    core_bus_master #(.N_CH(N), .ADDR_W(AW), .DATA_W(DW), .ARB_RR(1), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .bus(bus)
    );

    // Fixed-priority twin on a zero-wait slave, sharing the request inputs.
    core_bus_master #(.N_CH(N), .ADDR_W(AW), .DATA_W(DW), .ARB_RR(0), .TIMEOUT(TO)) dut_fp (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready2), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid2), .resp_rdata(resp_rdata2), .resp_err(resp_err2),
        .bus(bus2)
    );

    assign bus2.io_ack  = bus2.io_sel;
    assign bus2.io_dat4 = 32'h0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [1:0] m);
        int c;
        for (int i = 1; i <= N; i++) begin
            c = (last_g + i) % N;
            if (m[c]) return c;
        end
        return 0;
    endfunction

    always @(negedge clk) begin
        if (reset === 1'b1 && req_ready2 != 2'b00)
            chk("fixed_prio", 64'(req_ready2), 64'(req_valid & (~req_valid + 2'b01)));
    end

    task automatic do_txn(input logic [1:0] mask, input logic [1:0] we, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [7:0] be, input int d,
                          input logic [31:0] rd);
        int g;
        logic [31:0] ea, ew, e_rdata;
        logic [3:0]  eb;
        logic        ewe, e_err;
        @(posedge clk); #1;
        req_valid = mask; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        bus.io_ack = 1'b0;
        g = pick(mask);
        @(negedge clk);
        chk("ready", 64'(req_ready), 64'(1) << g);
        chk("rdata_hold", 64'(resp_rdata), 64'(last_rdata));
        chk("err_hold", 64'(resp_err), 64'(last_err));
        ea  = addr[g*32 +: 32];
        ewe = we[g];
        ew  = ewe ? wdata[g*32 +: 32] : 32'h0;
        eb  = be[g*4 +: 4];
        last_g = g;
        @(posedge clk); #1;
        req_valid = 2'b00;
        req_addr  = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom};
        req_be    = 8'($urandom);
        req_we    = 2'($urandom);
        for (int n = 1; n <= 8; n++) begin
            bus.io_ack  = (n == d);
            bus.io_dat4 = (n == d) ? rd : $urandom;
            @(negedge clk);
            chk("sel", 64'(bus.io_sel), 64'(1));
            chk("addr", 64'(bus.io_addr), 64'(ea));
            chk("we", 64'(bus.io_we), 64'(ewe));
            chk("be", 64'(bus.io_be), 64'(eb));
            chk("dat2", 64'(bus.io_dat2), 64'(ew));
            chk("resp_quiet", 64'(resp_valid), 64'(0));
            if (n == d || n == TO) break;
            @(posedge clk); #1;
        end
        e_err   = (d > TO);
        e_rdata = (e_err || ewe) ? 32'h0 : rd;
        @(posedge clk); #1;
        bus.io_ack  = 1'($urandom);
        bus.io_dat4 = $urandom;
        @(negedge clk);
        chk("sel_drop", 64'(bus.io_sel), 64'(0));
        chk("resp_valid", 64'(resp_valid), 64'(1) << g);
        chk("resp_rdata", 64'(resp_rdata), 64'(e_rdata));
        chk("resp_err", 64'(resp_err), 64'(e_err));
        last_rdata = e_rdata;
        last_err   = e_err;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int grants;
        reset = 1'b0;
        req_valid = 2'b11; req_we = 2'b00; req_addr = '0; req_wdata = '0; req_be = '0;
        bus.io_ack = 1'b0; bus.io_dat4 = '0;
        last_g = N - 1; last_rdata = '0; last_err = 1'b0;
        #3;
        chk("rst_ready", 64'(req_ready), 64'(0));
        chk("rst_sel", 64'(bus.io_sel), 64'(0));
        chk("rst_resp_valid", 64'(resp_valid), 64'(0));
        chk("rst_rdata", 64'(resp_rdata), 64'(0));
        chk("rst_err", 64'(resp_err), 64'(0));
        chk("rst_addr", 64'(bus.io_addr), 64'(0));
        chk("rst_we", 64'(bus.io_we), 64'(0));
        repeat (2) @(posedge clk);
        req_valid = 2'b00;
        @(negedge clk); #2 reset = 1'b1;

        // single read, ch0 wins the first arbitration
        do_txn(2'b11, 2'b00, {32'h0000_0200, 32'h0000_0010}, 64'h0, 8'hFF, 1, 32'h2002_0020);
        // write with wait states, ack on the last allowed cycle
        do_txn(2'b10, 2'b10, {32'h0000_0100, 32'h0000_0044}, {32'hDEAD_BEEF, 32'h1111_1111},
               {4'b0011, 4'b1111}, 4, 32'hCAFE_0000);
        // timeout
        do_txn(2'b01, 2'b00, {32'h0, 32'h0000_0080}, 64'h0, 8'hFF, 6, 32'h1234_5678);

        // both channels requesting continuously with immediate ack
        @(posedge clk); #1;
        req_valid = 2'b11; req_we = 2'b00; bus.io_ack = 1'b1; bus.io_dat4 = 32'h5A5A_0000;
        grants = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
                chk("rr_grant", 64'(req_ready), 64'(1) << pick(2'b11));
                last_g = pick(2'b11);
                grants++;
            end
            @(posedge clk); #1;
        end
        req_valid = 2'b00; bus.io_ack = 1'b0;
        chk("rr_count", 64'(grants), 64'(4));
        last_rdata = 32'h5A5A_0000; last_err = 1'b0;

        // stray ack while idle
        bus.io_ack = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stray_sel", 64'(bus.io_sel), 64'(0));
            chk("stray_resp", 64'(resp_valid), 64'(0));
            @(posedge clk); #1;
        end
        bus.io_ack = 1'b0;
        chk("stray_rdata", 64'(resp_rdata), 64'(last_rdata));

        for (int t = 0; t < 40; t++)
            do_txn(2'($urandom_range(1, 3)), 2'($urandom), {$urandom, $urandom},
                   {$urandom, $urandom}, 8'($urandom), $urandom_range(1, 6), $urandom);

        // asynchronous reset in the middle of a bus cycle
        @(posedge clk); #1;
        req_valid = 2'b10; req_we = 2'b00; bus.io_ack = 1'b0;
        @(posedge clk); #1;
        req_valid = 2'b11;
        @(negedge clk);
        chk("mid_sel_before", 64'(bus.io_sel), 64'(1));
        #2 reset = 1'b0;
        #1;
        chk("mid_sel", 64'(bus.io_sel), 64'(0));
        chk("mid_ready", 64'(req_ready), 64'(0));
        chk("mid_resp", 64'(resp_valid), 64'(0));
        req_valid = 2'b00;
        last_g = N - 1; last_rdata = '0; last_err = 1'b0;
        @(negedge clk); #2 reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("post_rst_resp", 64'(resp_valid), 64'(0));
        end
        do_txn(2'b11, 2'b00, {32'h0000_0300, 32'h0000_0030}, 64'h0, 8'hFF, 2, 32'h0BAD_F00D);

        @(posedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
